afe_reg_sequencer: RTL and testbench
====================================

// Module: afe_reg_sequencer
// PURPOSE
//  Sequencer between the pulse-ox top and the AFE4490 SPI master: after reset it waits out power-up,
//  issues a soft reset, writes the timing/gain init table, enables SPI readout, then per ADC_RDY
//  reads LED2VAL, ALED2VAL, LED1VAL, ALED1VAL and presents them as one sample bundle to memory/algo.
// PARAMETERS
//  PWRUP_CYCLES    1000  i_clk cycles held idle after reset before first SPI request
//  TIMEOUT_CYCLES  4096  max cycles waiting for i_spi_done per transaction before error
//  INIT_LEN        35    number of {addr,data} entries in init table (afe4490_pkg)
// PORTS
//  i_clk          in   1   system clock
//  i_rst_n        in   1   asynchronous active-low reset
//  i_reinit       in   1   1-cycle pulse: restart from power-up wait, clear sticky flags
//  i_adc_rdy      in   1   AFE ADC_RDY pin, asynchronous to i_clk
//  o_spi_dv       out  1   1-cycle request strobe to SPI master
//  o_spi_addr     out  8   register address, valid with o_spi_dv
//  o_spi_wr_data  out  24  write data, valid with o_spi_dv
//  o_spi_rd_wr    out  1   1=read, 0=write; valid with o_spi_dv
//  i_spi_done     in   1   1-cycle pulse: transaction complete
//  i_spi_rd_data  in   24  read data, valid with i_spi_done
//  o_init_done    out  1   high once readout enabled; low during init
//  o_sample_valid out  1   1-cycle pulse: all four sample outputs updated
//  o_led2/o_aled2/o_led1/o_aled1  out 24 each  raw register values (22b two's complement, sign-extended)
//  o_overrun      out  1   sticky: ADC_RDY edge arrived while a read burst was active
//  o_error        out  1   sticky: SPI timeout; sequencer parks in S_ERR
// BEHAVIOUR
//  Reset: all outputs 0, state S_PWRUP, counters 0. i_reinit is equivalent to reset except sync.
//  i_adc_rdy: 2-FF synchroniser + rising-edge detect; edge = 1-cycle internal pulse.
//  States: S_PWRUP -> S_SWRST -> S_INIT -> S_RDEN -> S_IDLE -> S_READ -> S_OUT -> S_IDLE; S_ERR.
//   S_PWRUP: count to PWRUP_CYCLES-1, then S_SWRST.
//   S_SWRST: write CONTROL0(0x00)=0x000008 (SW_RST), then S_INIT with idx=0.
//   S_INIT: write INIT_TABLE[idx]; idx++ on done; after idx==INIT_LEN-1 done -> S_RDEN.
//   S_RDEN: write CONTROL0=0x000001 (SPI_READ); on done o_init_done<=1, S_IDLE.
//   S_IDLE: on ADC_RDY edge -> S_READ, rd_idx=0. Edges before o_init_done are ignored.
//   S_READ: read addresses 0x2A,0x2B,0x2C,0x2D in order; each i_rd_data captured to a shadow reg.
//   S_OUT: copy shadows to outputs and pulse o_sample_valid same cycle; next cycle S_IDLE.
//  Transaction handshake (every SPI op): cycle 0 assert o_spi_dv with addr/data/rd_wr; hold
//   addr/data/rd_wr stable until i_spi_done; never re-assert o_spi_dv before done. Next op
//   issues no earlier than the cycle after done. i_spi_done outside a wait is ignored.
//  Timeout: per-op counter reset on o_spi_dv; reaching TIMEOUT_CYCLES -> o_error<=1, S_ERR;
//   S_ERR holds o_spi_dv=0 until reset/i_reinit.
//  Outputs hold last sample between pulses; partial bursts never reach outputs.
//  ADC_RDY edge in S_READ/S_OUT: o_overrun<=1, edge dropped (no queueing).
//  i_reinit mid-transaction: drop state immediately; o_init_done<=0; SPI master finishes
//   its frame alone, stray i_spi_done ignored while in S_PWRUP.
//  Latency: last done of burst -> o_sample_valid = 2 cycles (S_READ -> S_OUT).
// CONFIGURATION
//  AFE_ABSVAL_EN defined: burst extends to 6 reads, adding 0x2E LED2ABSVAL, 0x2F LED1ABSVAL;
//   ports o_led2_abs, o_led1_abs (24b, reset 0) exist and update with o_sample_valid.
//  Not defined: 4-read burst; those ports absent.
// STRUCTURE
//  afe4490_pkg: register address localparams (CONTROL0..DIAG), CTRL0_SW_RST=0x000008,
//   CTRL0_SPI_READ=0x000001, INIT_LEN, init_entry_t {addr[7:0],data[23:0]}, INIT_TABLE array,
//   state enum seq_state_t.
//  Sub-module: afe_rdy_sync (2-FF sync + rising-edge pulse). Table indexing stays in top.
// TESTING
//  Reset, PWRUP_CYCLES=16 -> first o_spi_dv at cycle 16, addr 0x00 data 0x000008 rd_wr=0.
//  Responder acks each op after 50 cycles -> exactly INIT_LEN+2 writes in table order, last
//   CONTROL0=0x000001, then o_init_done=1.
//  ADC_RDY rise; responder returns 0x000111,0x000222,0x3FFFFF,0x000444 -> one o_sample_valid,
//   outputs match, o_led1=0x3FFFFF unaltered; reads to 0x2A..0x2D in order.
//  Second ADC_RDY rise during burst -> o_overrun=1, only one o_sample_valid, next edge read ok.
//  Responder never acks, TIMEOUT_CYCLES=64 -> o_error=1 at cycle 64 after dv, no further dv.
//  i_reinit mid-init -> o_init_done=0, sequence restarts with CONTROL0 soft reset after power-up.

Source files
------------

// File: rtl/afe4490_pkg.sv
// afe4490_pkg
//   Shared definitions for the AFE4490 register sequencer: register map
//   addresses, CONTROL0 command words, the init table entry type and the
//   power-on init table (timing windows for a 500 Hz PRF plus gain/LED setup),
//   and the sequencer state enum.
//   Used by afe_reg_sequencer.
package afe4490_pkg;

  localparam logic [7:0] CONTROL0      = 8'h00, LED2STC       = 8'h01, LED2ENDC      = 8'h02;
  localparam logic [7:0] LED2LEDSTC    = 8'h03, LED2LEDENDC   = 8'h04, ALED2STC      = 8'h05;
  localparam logic [7:0] ALED2ENDC     = 8'h06, LED1STC       = 8'h07, LED1ENDC      = 8'h08;
  localparam logic [7:0] LED1LEDSTC    = 8'h09, LED1LEDENDC   = 8'h0A, ALED1STC      = 8'h0B;
  localparam logic [7:0] ALED1ENDC     = 8'h0C, LED2CONVST    = 8'h0D, LED2CONVEND   = 8'h0E;
  localparam logic [7:0] ALED2CONVST   = 8'h0F, ALED2CONVEND  = 8'h10, LED1CONVST    = 8'h11;
  localparam logic [7:0] LED1CONVEND   = 8'h12, ALED1CONVST   = 8'h13, ALED1CONVEND  = 8'h14;
  localparam logic [7:0] ADCRSTSTCT0   = 8'h15, ADCRSTENDCT0  = 8'h16, ADCRSTSTCT1   = 8'h17;
  localparam logic [7:0] ADCRSTENDCT1  = 8'h18, ADCRSTSTCT2   = 8'h19, ADCRSTENDCT2  = 8'h1A;
  localparam logic [7:0] ADCRSTSTCT3   = 8'h1B, ADCRSTENDCT3  = 8'h1C, PRPCOUNT      = 8'h1D;
  localparam logic [7:0] CONTROL1      = 8'h1E, TIAGAIN       = 8'h20, TIA_AMB_GAIN  = 8'h21;
  localparam logic [7:0] LEDCNTRL      = 8'h22, CONTROL2      = 8'h23, ALARM         = 8'h29;
  localparam logic [7:0] LED2VAL       = 8'h2A, ALED2VAL      = 8'h2B, LED1VAL       = 8'h2C;
  localparam logic [7:0] ALED1VAL      = 8'h2D, LED2ABSVAL    = 8'h2E, LED1ABSVAL    = 8'h2F;
  localparam logic [7:0] DIAG          = 8'h30;

  localparam logic [23:0] CTRL0_SW_RST   = 24'h000008;
  localparam logic [23:0] CTRL0_SPI_READ = 24'h000001;

  localparam int INIT_LEN = 35;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } init_entry_t;

  // Written in this order after the soft reset; timing registers first so the
  // timer engine is fully programmed before CONTROL1 enables it.
  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{LED2STC,      24'd6050}, '{LED2ENDC,     24'd7998}, '{LED2LEDSTC,   24'd6000},
    '{LED2LEDENDC,  24'd7999}, '{ALED2STC,     24'd50},   '{ALED2ENDC,    24'd1998},
    '{LED1STC,      24'd2050}, '{LED1ENDC,     24'd3998}, '{LED1LEDSTC,   24'd2000},
    '{LED1LEDENDC,  24'd3999}, '{ALED1STC,     24'd4050}, '{ALED1ENDC,    24'd5998},
    '{LED2CONVST,   24'd4},    '{LED2CONVEND,  24'd1999}, '{ALED2CONVST,  24'd2004},
    '{ALED2CONVEND, 24'd3999}, '{LED1CONVST,   24'd4004}, '{LED1CONVEND,  24'd5999},
    '{ALED1CONVST,  24'd6004}, '{ALED1CONVEND, 24'd7999}, '{ADCRSTSTCT0,  24'd0},
    '{ADCRSTENDCT0, 24'd3},    '{ADCRSTSTCT1,  24'd2000}, '{ADCRSTENDCT1, 24'd2003},
    '{ADCRSTSTCT2,  24'd4000}, '{ADCRSTENDCT2, 24'd4003}, '{ADCRSTSTCT3,  24'd6000},
    '{ADCRSTENDCT3, 24'd6003}, '{PRPCOUNT,     24'd7999}, '{CONTROL1,     24'h000107},
    '{TIAGAIN,      24'h000000}, '{TIA_AMB_GAIN, 24'h000001}, '{LEDCNTRL,   24'h011414},
    '{CONTROL2,     24'h000100}, '{ALARM,        24'h000000}
  };

  typedef enum logic [2:0] {
    S_PWRUP, S_SWRST, S_INIT, S_RDEN, S_IDLE, S_READ, S_OUT, S_ERR
  } seq_state_t;

endpackage

// File: rtl/afe_rdy_sync.sv
// afe_rdy_sync
//   Brings the AFE ADC_RDY pin into the i_clk domain through a 2-FF
//   synchroniser and produces a 1-cycle pulse on each rising edge.
// Ports
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_async   raw ADC_RDY pin
//   o_rise    1-cycle pulse per synchronised rising edge
module afe_rdy_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [2:0] sync_q;

  // Bits 0/1 are the metastability stages; bit 2 is the delayed copy for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], i_async};
    end
  end

  assign o_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/afe_reg_sequencer.sv
// afe_reg_sequencer
//   Drives the AFE4490 SPI master: power-up wait, soft reset, init table,
//   SPI readout enable, then one read burst per ADC_RDY rising edge, presented
//   as a single sample bundle with a 1-cycle o_sample_valid.
// Optional feature macro: AFE_ABSVAL_EN (adds LED2ABSVAL/LED1ABSVAL reads and
//   the o_led2_abs/o_led1_abs ports).
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_reinit                  sync restart pulse, same effect as reset
//   i_adc_rdy                 asynchronous ADC_RDY pin
//   o_spi_dv/addr/wr_data/rd_wr  request to SPI master (1=read)
//   i_spi_done/i_spi_rd_data  completion pulse and read data
//   o_init_done               readout enabled
//   o_sample_valid            1-cycle pulse, sample outputs updated
//   o_led2/o_aled2/o_led1/o_aled1  raw 24-bit register values
//   o_overrun, o_error        sticky flags
module afe_reg_sequencer
  import afe4490_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_reinit,
  input  logic        i_adc_rdy,
  output logic        o_spi_dv,
  output logic [7:0]  o_spi_addr,
  output logic [23:0] o_spi_wr_data,
  output logic        o_spi_rd_wr,
  input  logic        i_spi_done,
  input  logic [23:0] i_spi_rd_data,
  output logic        o_init_done,
  output logic        o_sample_valid,
  output logic [23:0] o_led2,
  output logic [23:0] o_aled2,
  output logic [23:0] o_led1,
  output logic [23:0] o_aled1,
`ifdef AFE_ABSVAL_EN
  output logic [23:0] o_led2_abs,
  output logic [23:0] o_led1_abs,
`endif
  output logic        o_overrun,
  output logic        o_error
);

`ifdef AFE_ABSVAL_EN
  localparam int RD_LEN = 6;
`else
  localparam int RD_LEN = 4;
`endif
  localparam int RD_W   = $clog2(RD_LEN);
  localparam int INIT_W = $clog2(INIT_LEN);
  localparam int PWR_W  = $clog2(PWRUP_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_LEN - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);
  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWRUP_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state;
  logic [PWR_W-1:0]  pwr_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [INIT_W-1:0] init_idx;
  logic [INIT_W-1:0] init_nxt;
  logic [RD_W-1:0]   rd_idx;
  logic [RD_W-1:0]   rd_nxt;
  init_entry_t       init_nxt_entry;
  logic [23:0]       shadow [RD_LEN];
  logic              rdy_rise;

  afe_rdy_sync u_rdy_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_adc_rdy),
    .o_rise  (rdy_rise)
  );

  // Lookahead into the table so the next write can be launched on the same
  // edge that accepts the current done.
  always_comb begin
    init_nxt       = init_idx + INIT_W'(1);
    rd_nxt         = rd_idx + RD_W'(1);
    init_nxt_entry = '0;
    if (init_nxt < INIT_W'(INIT_LEN)) begin
      init_nxt_entry = INIT_TABLE[init_nxt];
    end
  end

  // Launching an op restarts the per-op timeout; addr/data stay registered
  // until the next launch so they remain stable through the wait for done.
  task automatic issue_op(input logic [7:0] addr, input logic [23:0] data, input logic rd);
    o_spi_dv      <= 1'b1;
    o_spi_addr    <= addr;
    o_spi_wr_data <= data;
    o_spi_rd_wr   <= rd;
    tmo_cnt       <= '0;
  endtask

  task automatic clear_all();
    state          <= S_PWRUP;
    pwr_cnt        <= '0;
    tmo_cnt        <= '0;
    init_idx       <= '0;
    rd_idx         <= '0;
    for (int i = 0; i < RD_LEN; i++) shadow[i] <= '0;
    o_spi_dv       <= 1'b0;
    o_spi_addr     <= '0;
    o_spi_wr_data  <= '0;
    o_spi_rd_wr    <= 1'b0;
    o_init_done    <= 1'b0;
    o_sample_valid <= 1'b0;
    o_led2         <= '0;
    o_aled2        <= '0;
    o_led1         <= '0;
    o_aled1        <= '0;
`ifdef AFE_ABSVAL_EN
    o_led2_abs     <= '0;
    o_led1_abs     <= '0;
`endif
    o_overrun      <= 1'b0;
    o_error        <= 1'b0;
  endtask

  // Main sequencer. Every SPI-issuing state is always waiting on exactly one
  // outstanding op, so done handling and timeout are shared across them.
  // A done seen in any other state (e.g. after i_reinit) is simply ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clear_all();
    end else if (i_reinit) begin
      clear_all();
    end else begin
      o_spi_dv       <= 1'b0;
      o_sample_valid <= 1'b0;
      if (rdy_rise && (state == S_READ || state == S_OUT)) begin
        o_overrun <= 1'b1;
      end
      unique case (state)
        S_PWRUP: begin
          if (pwr_cnt == PWR_LAST) begin
            state <= S_SWRST;
            issue_op(CONTROL0, CTRL0_SW_RST, 1'b0);
          end else begin
            pwr_cnt <= pwr_cnt + PWR_W'(1);
          end
        end
        S_SWRST, S_INIT, S_RDEN, S_READ: begin
          if (i_spi_done) begin
            case (state)
              S_SWRST: begin
                state    <= S_INIT;
                init_idx <= '0;
                issue_op(INIT_TABLE[0].addr, INIT_TABLE[0].data, 1'b0);
              end
              S_INIT: begin
                if (init_idx == INIT_LAST) begin
                  state <= S_RDEN;
                  issue_op(CONTROL0, CTRL0_SPI_READ, 1'b0);
                end else begin
                  init_idx <= init_nxt;
                  issue_op(init_nxt_entry.addr, init_nxt_entry.data, 1'b0);
                end
              end
              S_RDEN: begin
                o_init_done <= 1'b1;
                state       <= S_IDLE;
              end
              default: begin
                shadow[rd_idx] <= i_spi_rd_data;
                if (rd_idx == RD_LAST) begin
                  state <= S_OUT;
                end else begin
                  rd_idx <= rd_nxt;
                  issue_op(LED2VAL + 8'(rd_nxt), '0, 1'b1);
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            o_error <= 1'b1;
            state   <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_IDLE: begin
          if (rdy_rise) begin
            state  <= S_READ;
            rd_idx <= '0;
            issue_op(LED2VAL, '0, 1'b1);
          end
        end
        S_OUT: begin
          o_led2         <= shadow[0];
          o_aled2        <= shadow[1];
          o_led1         <= shadow[2];
          o_aled1        <= shadow[3];
`ifdef AFE_ABSVAL_EN
          o_led2_abs     <= shadow[4];
          o_led1_abs     <= shadow[5];
`endif
          o_sample_valid <= 1'b1;
          state          <= S_IDLE;
        end
        S_ERR: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afe_reg_sequencer.sv
// tb_afe_reg_sequencer
//   Self-checking bench for afe_reg_sequencer with short power-up/timeout
//   parameters. An SPI responder acks requests after a programmable delay and
//   remembers the last value it returned per register address; sample outputs
//   are predicted from those remembered values.
module tb_afe_reg_sequencer;
  import afe4490_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, reinit, adcRdy;
  logic        spiDone = 1'b0;
  logic [23:0] spiRdData = '0;
  logic        spiDv, spiRdWr, initDone, sampleValid, overrun, error;
  logic [7:0]  spiAddr;
  logic [23:0] spiWrData, led2, aled2, led1, aled1;
`ifdef AFE_ABSVAL_EN
  logic [23:0] led2Abs, led1Abs;
`endif

  int total = 0;
  int bad   = 0;

  // Stimulus-side knobs, written only by the main initial block.
  logic        ackEn;
  int          ackLat;
  logic        usePattern;
  logic [23:0] rdPattern [4];

  // Responder/monitor state, written only by the negedge process.
  logic [7:0]  logAddr [$];
  logic [23:0] logData [$];
  logic        logRd   [$];
  logic [23:0] expVal  [64];
  int          dvCnt = 0, validCnt = 0, protoErr = 0, negCnt = 0, doneAt = 0, lastLat = 0;
  int          waitCnt = 0;
  logic        busy = 1'b0;
  logic [7:0]  hAddr = '0;
  logic [23:0] hData = '0;
  logic        hRd = 1'b0;
  logic [21:0] r22;
  logic [23:0] rdVal;

  afe_reg_sequencer #(.PWRUP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_reinit       (reinit),
    .i_adc_rdy      (adcRdy),
    .o_spi_dv       (spiDv),
    .o_spi_addr     (spiAddr),
    .o_spi_wr_data  (spiWrData),
    .o_spi_rd_wr    (spiRdWr),
    .i_spi_done     (spiDone),
    .i_spi_rd_data  (spiRdData),
    .o_init_done    (initDone),
    .o_sample_valid (sampleValid),
    .o_led2         (led2),
    .o_aled2        (aled2),
    .o_led1         (led1),
    .o_aled1        (aled1),
`ifdef AFE_ABSVAL_EN
    .o_led2_abs     (led2Abs),
    .o_led1_abs     (led1Abs),
`endif
    .o_overrun      (overrun),
    .o_error        (error)
  );

  always #5 clk = ~clk;

  // SPI responder and monitor, on the falling edge away from the DUT's active edge.
  always @(negedge clk) begin
    negCnt++;
    spiDone = 1'b0;
    if (sampleValid) begin
      validCnt++;
      lastLat = negCnt - doneAt;
    end
    if (spiDv) begin
      if (busy) protoErr++;
      dvCnt++;
      logAddr.push_back(spiAddr);
      logData.push_back(spiWrData);
      logRd.push_back(spiRdWr);
      busy    = 1'b1;
      waitCnt = ackLat;
      hAddr   = spiAddr;
      hData   = spiWrData;
      hRd     = spiRdWr;
    end else if (busy) begin
      if (spiAddr !== hAddr || spiWrData !== hData || spiRdWr !== hRd) protoErr++;
      if (ackEn) begin
        if (waitCnt <= 1) begin
          if (usePattern && hAddr >= 8'h2A && hAddr <= 8'h2D) begin
            rdVal = rdPattern[hAddr[1:0] - 2'd2];
          end else begin
            r22   = 22'($urandom());
            rdVal = {{2{r22[21]}}, r22};
          end
          spiRdData = rdVal;
          if (hRd) expVal[hAddr[5:0]] = rdVal;
          spiDone = 1'b1;
          busy    = 1'b0;
          doneAt  = negCnt;
        end else begin
          waitCnt--;
        end
      end
    end
    if (!rst_n || reinit) busy = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One ADC_RDY pulse held high for the given number of cycles.
  task automatic applyStimulus(input int highCyc);
    @(posedge clk); #1 adcRdy = 1'b1;
    repeat (highCyc) @(posedge clk);
    #1 adcRdy = 1'b0;
  endtask

  task automatic pulseReinit();
    @(posedge clk); #1 reinit = 1'b1;
    @(posedge clk); #1 reinit = 1'b0;
  endtask

  task automatic countToDv(output int cyc);
    cyc = 0;
    while (!spiDv && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic waitInitDone();
    int n;
    n = 0;
    while (!initDone && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("init_done", initDone, 1'b1);
  endtask

  task automatic waitValid(input int v0);
    int n;
    n = 0;
    while (validCnt == v0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("valid_seen", validCnt - v0, 1);
  endtask

  task automatic checkSample(input string tag);
    checkOutput({tag, "_led2"},  led2,  expVal[6'h2A]);
    checkOutput({tag, "_aled2"}, aled2, expVal[6'h2B]);
    checkOutput({tag, "_led1"},  led1,  expVal[6'h2C]);
    checkOutput({tag, "_aled1"}, aled1, expVal[6'h2D]);
    checkOutput({tag, "_lat"},   lastLat, 2);
  endtask

  function automatic logic [7:0] expInitAddr(input int k);
    if (k < 30)      return 8'(k + 1);
    else if (k < 34) return 8'(32 + k - 30);
    else             return 8'h29;
  endfunction

  task automatic checkInitLog(input int base, input string tag);
    int n;
    logic [63:0] exp;
    n = logAddr.size() - base;
    checkOutput({tag, "_nwrites"}, n, INIT_LEN + 2);
    for (int k = 0; k < INIT_LEN + 2 && k < n; k++) begin
      if (k == 0)                 exp = {8'h00, 24'h000008, 1'b0};
      else if (k == INIT_LEN + 1) exp = {8'h00, 24'h000001, 1'b0};
      else                        exp = {expInitAddr(k - 1), INIT_TABLE[k - 1].data, 1'b0};
      checkOutput($sformatf("%s_op%0d", tag, k),
                  {logAddr[base + k], logData[base + k], logRd[base + k]}, exp);
    end
  endtask

  initial begin
    int cyc, base, v0, d0;
    rst_n = 1'b0; reinit = 1'b0; adcRdy = 1'b0;
    ackEn = 1'b1; ackLat = 50; usePattern = 1'b0;
    rdPattern = '{24'h000111, 24'h000222, 24'h3FFFFF, 24'h000444};
    for (int i = 0; i < 64; i++) expVal[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dv", spiDv, 0);
    checkOutput("rst_init_done", initDone, 0);
    checkOutput("rst_valid", sampleValid, 0);
    checkOutput("rst_led1", led1, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_error", error, 0);

    $display("[TB] power-up and init");
    base  = logAddr.size();
    rst_n = 1'b1;
    countToDv(cyc);
    checkOutput("pwrup_cycles", cyc, 16);
    checkOutput("first_op", {spiAddr, spiWrData, spiRdWr}, {8'h00, 24'h000008, 1'b0});
    checkOutput("init_done_low", initDone, 0);
    waitInitDone();
    checkInitLog(base, "init");

    $display("[TB] directed sample");
    usePattern = 1'b1;
    base = logAddr.size();
    v0   = validCnt;
    applyStimulus(4);
    waitValid(v0);
    checkOutput("dir_led2",  led2,  24'h000111);
    checkOutput("dir_aled2", aled2, 24'h000222);
    checkOutput("dir_led1",  led1,  24'h3FFFFF);
    checkOutput("dir_aled1", aled1, 24'h000444);
    checkOutput("dir_lat", lastLat, 2);
    checkOutput("dir_nreads", logAddr.size() - base, 4);
    for (int i = 0; i < 4 && base + i < logAddr.size(); i++)
      checkOutput($sformatf("dir_rd%0d", i), {logAddr[base + i], logRd[base + i]}, {8'(8'h2A + i), 1'b1});
    checkOutput("dir_overrun", overrun, 0);

    $display("[TB] overrun");
    usePattern = 1'b0;
    v0 = validCnt;
    applyStimulus(3);
    repeat (30) @(posedge clk);
    applyStimulus(3);
    waitValid(v0);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("ovr_one_valid", validCnt - v0, 1);
    checkOutput("ovr_flag", overrun, 1);
    checkSample("ovr");
    v0 = validCnt;
    applyStimulus(3);
    waitValid(v0);
    checkSample("ovr_next");

    $display("[TB] random bursts");
    for (int it = 0; it < 6; it++) begin
      ackLat = $urandom_range(1, 20);
      v0 = validCnt;
      applyStimulus($urandom_range(2, 6));
      waitValid(v0);
      checkSample($sformatf("rnd%0d", it));
      repeat ($urandom_range(3, 15)) @(posedge clk);
    end

    $display("[TB] reinit mid-init");
    ackLat = 50;
    pulseReinit();
    checkOutput("reinit_init_done", initDone, 0);
    checkOutput("reinit_overrun", overrun, 0);
    checkOutput("reinit_led1", led1, 0);
    cyc = 0;
    while (logAddr.size() < base + 8 && cyc < 2000) begin
      base = (cyc == 0) ? logAddr.size() : base;
      @(posedge clk); #1;
      cyc++;
    end
    repeat (20) @(posedge clk);
    base = logAddr.size();
    pulseReinit();
    checkOutput("reinit2_init_done", initDone, 0);
    countToDv(cyc);
    checkOutput("reinit_pwrup_cycles", cyc, 16);
    checkOutput("reinit_first_op", {spiAddr, spiWrData, spiRdWr}, {8'h00, 24'h000008, 1'b0});
    waitInitDone();
    checkInitLog(base, "reinit");
    ackLat = 10;
    v0 = validCnt;
    applyStimulus(3);
    waitValid(v0);
    checkSample("post_reinit");

    $display("[TB] timeout");
    ackEn = 1'b0;
    v0 = validCnt;
    @(posedge clk); #1 adcRdy = 1'b1;
    countToDv(cyc);
    checkOutput("tmo_dv_seen", spiDv, 1);
    adcRdy = 1'b0;
    cyc = 0;
    while (!error && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("tmo_cycles", cyc, 64);
    d0 = dvCnt;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("tmo_no_dv", dvCnt - d0, 0);
    checkOutput("tmo_error_sticky", error, 1);
    checkOutput("tmo_no_valid", validCnt - v0, 0);
    checkOutput("tmo_led2_held", led2, expVal[6'h2A]);

    checkOutput("protocol", protoErr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
